// File: rtl/dlfloat16_to_int_pipe.sv
// -----------------------------------------------------------------------------
// dlfloat16_to_int_pipe
//
// Two-stage pipelined DLfloat16 -> integer converter with valid/ready flow
// control. The DLfloat16 operand is laid out as [15] sign, [14:9] exponent
// (bias 31), [8:0] fraction with an implicit leading one. Exponent 0 is read
// as zero and exponent 63 as Inf/NaN.
//
// Stage 1 decodes the operand and aligns the mantissa to an integer part plus
// guard/sticky bits. Stage 2 rounds, range-checks against the selected output
// format, applies the sign and produces the exception flags.
//
// Parameters
//   INT_W         integer result width, 8..64
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset, empties both stages
//   in_valid      input transaction present
//   in_ready      converter accepts the input this cycle
//   float_in      DLfloat16 operand
//   rnd_mode      00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   signed_out    1 = signed result, 0 = unsigned result
//   out_valid     result present
//   out_ready     consumer accepts the result
//   int_out       converted integer
//   exceptions    [4] invalid, [3] div-by-zero (0), [2] overflow,
//                 [1] underflow (0), [0] inexact
//   flags_sticky  OR of exceptions over all consumed results
//   flags_clr     synchronous clear of flags_sticky
// -----------------------------------------------------------------------------
module dlfloat16_to_int_pipe #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      float_in,
    input  logic [1:0]       rnd_mode,
    input  logic             signed_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] int_out,
    output logic [4:0]       exceptions,
    output logic [4:0]       flags_sticky,
    input  logic             flags_clr
);

    // Range checks are done in a width that holds both the 34-bit rounded
    // magnitude and 2^INT_W for the widest legal INT_W.
    localparam int              WW       = 66;
    localparam logic [WW-1:0]   ONE      = 66'd1;
    localparam logic [WW-1:0]   SMAX     = (ONE << (INT_W - 1)) - ONE;
    localparam logic [WW-1:0]   SMIN_MAG = ONE << (INT_W - 1);
    localparam logic [WW-1:0]   UMAX     = (ONE << INT_W) - ONE;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Unbiased exponent 9 (biased 40) puts the binary point just right of
    // the 10-bit mantissa: at or above it the value is an exact integer.
    localparam logic [5:0] EXP_INT = 6'd40;
    localparam logic [5:0] EXP_MAX = 6'd63;

    // -------------------------------------------------------------------------
    // Flow control
    // -------------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_load;
    logic s1_load;
    logic out_xfer;

    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        out_xfer = out_valid_q && out_ready;
    end

    assign in_ready = s1_load;

    // -------------------------------------------------------------------------
    // Stage 1: decode and align
    // -------------------------------------------------------------------------
    logic [9:0]  mant;
    logic [5:0]  exp_in;
    logic [5:0]  lsh;
    logic [5:0]  rsh;
    logic [49:0] ext;
    logic [33:0] int_aligned;
    logic        guard_in;
    logic        sticky_in;

    always_comb begin
        exp_in      = float_in[14:9];
        mant        = {1'b1, float_in[8:0]};
        lsh         = 6'd0;
        rsh         = 6'd0;
        ext         = 50'd0;
        int_aligned = 34'd0;
        guard_in    = 1'b0;
        sticky_in   = 1'b0;
        if (exp_in >= EXP_INT) begin
            // Exact integer; largest shift is 22, so the result fits 32 bits.
            lsh         = exp_in - EXP_INT;
            int_aligned = {24'd0, mant} << lsh;
        end else begin
            // Mantissa sits above 40 zero bits so nothing is lost for any
            // right shift up to 39; bit 39 is then the first discarded bit.
            rsh         = EXP_INT - exp_in;
            ext         = {mant, 40'd0} >> rsh;
            int_aligned = {24'd0, ext[49:40]};
            guard_in    = ext[39];
            sticky_in   = |ext[38:0];
        end
    end

    logic        s1_sign_q,    s1_sign_d;
    logic        s1_zero_q,    s1_zero_d;
    logic        s1_special_q, s1_special_d;
    logic [33:0] s1_int_q,     s1_int_d;
    logic        s1_guard_q,   s1_guard_d;
    logic        s1_sticky_q,  s1_sticky_d;
    logic [1:0]  s1_rnd_q,     s1_rnd_d;
    logic        s1_signed_q,  s1_signed_d;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_zero_d    = s1_zero_q;
        s1_special_d = s1_special_q;
        s1_int_d     = s1_int_q;
        s1_guard_d   = s1_guard_q;
        s1_sticky_d  = s1_sticky_q;
        s1_rnd_d     = s1_rnd_q;
        s1_signed_d  = s1_signed_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d    = float_in[15];
                s1_zero_d    = (exp_in == 6'd0);
                s1_special_d = (exp_in == EXP_MAX);
                s1_int_d     = int_aligned;
                s1_guard_d   = guard_in;
                s1_sticky_d  = sticky_in;
                s1_rnd_d     = rnd_mode;
                s1_signed_d  = signed_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_special_q <= 1'b0;
            s1_int_q     <= 34'd0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_rnd_q     <= 2'b00;
            s1_signed_q  <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_special_q <= s1_special_d;
            s1_int_q     <= s1_int_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_rnd_q     <= s1_rnd_d;
            s1_signed_q  <= s1_signed_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: round, range check, sign apply, flags
    // -------------------------------------------------------------------------
    logic          discard;
    logic          round_up;
    logic [33:0]   mag;
    logic [WW-1:0] mag_w;
    logic [WW-1:0] res_w;
    logic [4:0]    exc_w;

    always_comb begin
        discard = s1_guard_q || s1_sticky_q;
        case (s1_rnd_q)
            RM_RNE:  round_up = s1_guard_q && (s1_sticky_q || s1_int_q[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_RUP:  round_up = discard && !s1_sign_q;
            RM_RDN:  round_up = discard && s1_sign_q;
            default: round_up = 1'b0;
        endcase
        mag   = s1_int_q + {33'd0, round_up};
        mag_w = {32'd0, mag};

        res_w = '0;
        exc_w = 5'b00000;
        if (s1_zero_q) begin
            res_w = '0;
        end else if (s1_special_q) begin
            exc_w[4] = 1'b1;
            if (s1_signed_q) begin
                // Two's complement min is -SMIN_MAG; truncation to INT_W
                // bits below gives the 100..0 pattern.
                res_w = s1_sign_q ? SMIN_MAG : SMAX;
            end else begin
                res_w = s1_sign_q ? '0 : UMAX;
            end
        end else begin
            exc_w[0] = discard;
            if (s1_signed_q) begin
                if (!s1_sign_q) begin
                    if (mag_w > SMAX) begin
                        res_w    = SMAX;
                        exc_w[2] = 1'b1;
                    end else begin
                        res_w = mag_w;
                    end
                end else begin
                    if (mag_w > SMIN_MAG) begin
                        res_w    = SMIN_MAG;
                        exc_w[2] = 1'b1;
                    end else begin
                        res_w = (~mag_w) + ONE;
                    end
                end
            end else begin
                if (s1_sign_q) begin
                    // Negative values clamp to 0; -0 after rounding is exact.
                    res_w    = '0;
                    exc_w[2] = (mag != 34'd0);
                end else if (mag_w > UMAX) begin
                    res_w    = UMAX;
                    exc_w[2] = 1'b1;
                end else begin
                    res_w = mag_w;
                end
            end
        end
    end

    logic [INT_W-1:0] int_out_q, int_out_d;
    logic [4:0]       exc_q,     exc_d;
    logic [4:0]       sticky_q,  sticky_d;

    always_comb begin
        out_valid_d = out_valid_q;
        int_out_d   = int_out_q;
        exc_d       = exc_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            // Hold the last result when a bubble moves in, so the outputs
            // only change when a real result arrives.
            if (s1_valid_q) begin
                int_out_d = res_w[INT_W-1:0];
                exc_d     = exc_w;
            end
        end

        // Clear takes effect before the coinciding transfer's flags are set.
        sticky_d = flags_clr ? 5'b00000 : sticky_q;
        if (out_xfer) begin
            sticky_d = sticky_d | exc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            int_out_q   <= '0;
            exc_q       <= 5'b00000;
            sticky_q    <= 5'b00000;
        end else begin
            out_valid_q <= out_valid_d;
            int_out_q   <= int_out_d;
            exc_q       <= exc_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign int_out      = int_out_q;
    assign exceptions   = exc_q;
    assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_dlfloat16_to_int_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for dlfloat16_to_int_pipe. Two instances (INT_W=32 and INT_W=8)
// share all inputs and run in lockstep; handshakes follow the 32-bit one.
// Directed tests use hand-derived constants; the random test uses a
// behavioural model built from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_dlfloat16_to_int_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] float_in = 16'h0000;
    logic [1:0]  rnd_mode = 2'b00;
    logic        signed_out = 1'b1;
    logic        out_ready = 1'b0;
    logic        flags_clr = 1'b0;

    logic        in_ready32, out_valid32;
    logic [31:0] int_out32;
    logic [4:0]  exc32, sticky32;
    logic        in_ready8, out_valid8;
    logic [7:0]  int_out8;
    logic [4:0]  exc8, sticky8;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dlfloat16_to_int_pipe #(.INT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .float_in(float_in), .rnd_mode(rnd_mode), .signed_out(signed_out),
        .out_valid(out_valid32), .out_ready(out_ready), .int_out(int_out32),
        .exceptions(exc32), .flags_sticky(sticky32), .flags_clr(flags_clr)
    );

    dlfloat16_to_int_pipe #(.INT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .float_in(float_in), .rnd_mode(rnd_mode), .signed_out(signed_out),
        .out_valid(out_valid8), .out_ready(out_ready), .int_out(int_out8),
        .exceptions(exc8), .flags_sticky(sticky8), .flags_clr(flags_clr)
    );

    // Reference: value = (512+frac) * 2^(E-9); rounding by comparing the
    // remainder with half of the divisor; clamp the signed value to range.
    function automatic void ref_conv(input logic [15:0] f, input logic [1:0] rm,
                                     input logic so, input int w,
                                     output longint res, output logic [4:0] exc);
        longint lo, hi, m, ip, r, d, half, mm, v;
        int     e;
        logic   s;
        bit     inc;
        s   = f[15];
        exc = 5'b00000;
        res = 0;
        hi  = so ? ((longint'(1) << (w - 1)) - 1) : ((longint'(1) << w) - 1);
        lo  = so ? -(longint'(1) << (w - 1)) : 0;
        if (f[14:9] == 6'd63) begin
            exc[4] = 1'b1;
            res    = s ? lo : hi;
        end else if (f[14:9] != 6'd0) begin
            e = int'(f[14:9]) - 31;
            m = 512 + longint'(f[8:0]);
            if (e >= 9) begin
                ip = m << (e - 9);
                r = 0;
                half = 1;
            end else begin
                d    = longint'(1) << (9 - e);
                ip   = m / d;
                r    = m % d;
                half = d / 2;
            end
            case (rm)
                2'b00:   inc = (r > half) || (r == half && ip[0]);
                2'b10:   inc = (r != 0) && !s;
                2'b11:   inc = (r != 0) && s;
                default: inc = 1'b0;
            endcase
            mm = ip + (inc ? 1 : 0);
            if (r != 0) exc[0] = 1'b1;
            v = s ? -mm : mm;
            if (v > hi) begin
                res = hi; exc[2] = 1'b1;
            end else if (v < lo) begin
                res = lo; exc[2] = 1'b1;
            end else begin
                res = v;
            end
        end
    endfunction

    // One isolated transaction with out_ready=1. Called at posedge+1.
    task automatic xfer(input logic [15:0] f, input logic [1:0] rm, input logic so,
                        input logic clr_at_out,
                        output logic [31:0] r32, output logic [4:0] e32,
                        output logic [7:0] r8, output logic [4:0] e8,
                        output int lat, output bit ok);
        int n;
        ok = 1'b1;
        out_ready = 1'b1;
        float_in = f; rnd_mode = rm; signed_out = so; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready32 && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready32) ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid32) ok = 1'b0;
        r32 = int_out32; e32 = exc32; r8 = int_out8; e8 = exc8;
        flags_clr = clr_at_out;
        @(posedge clk); #1;
        flags_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready32); else passed++;
        checks++; if (out_valid32 !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid32); else passed++;
        checks++; if (int_out32 !== 32'd0 || exc32 !== 5'd0 || sticky32 !== 5'd0)
            $display("FAIL reset_outputs got=%h/%b/%b want=0/0/0", int_out32, exc32, sticky32); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [15:0] fv [3] = '{16'h3E00, 16'h0000, 16'h8155};
        logic [31:0] wv [3] = '{32'd1, 32'd0, 32'd0};
        logic [31:0] r32; logic [4:0] e32; logic [7:0] r8; logic [4:0] e8;
        int lat; bit ok;
        for (int i = 0; i < 3; i++) begin
            xfer(fv[i], 2'b00, 1'b1, 1'b0, r32, e32, r8, e8, lat, ok);
            $display("basic f=%h -> %h exc=%b lat=%0d", fv[i], r32, e32, lat);
            checks++; if (!ok || r32 !== wv[i] || e32 !== 5'd0)
                $display("FAIL basic_%h got=%h/%b want=%h/00000", fv[i], r32, e32, wv[i]); else passed++;
            if (i == 0) begin
                checks++; if (lat !== 2) $display("FAIL basic_latency got=%0d want=2", lat); else passed++;
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] fv [8] = '{16'h4080, 16'h4080, 16'h4080, 16'h4080,
                                16'hC080, 16'hC080, 16'hC080, 16'h4180};
        logic [1:0]  mv [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
        logic [31:0] wv [8] = '{32'd2, 32'd2, 32'd3, 32'd2,
                                32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd4};
        logic [31:0] r32; logic [4:0] e32; logic [7:0] r8; logic [4:0] e8;
        int lat; bit ok;
        for (int i = 0; i < 8; i++) begin
            xfer(fv[i], mv[i], 1'b1, 1'b0, r32, e32, r8, e8, lat, ok);
            $display("round f=%h rm=%0d -> %h exc=%b", fv[i], mv[i], r32, e32);
            checks++; if (!ok || r32 !== wv[i] || e32 !== 5'b00001)
                $display("FAIL round_%h_rm%0d got=%h/%b want=%h/00001", fv[i], mv[i], r32, e32, wv[i]); else passed++;
        end
    endtask

    task automatic test_range();
        logic [15:0] fv [10] = '{16'h7C00, 16'h7C00, 16'hFC00, 16'hFC00, 16'h7E00,
                                 16'hFE00, 16'h4800, 16'h4A00, 16'h4E00, 16'h4E00};
        logic        sv [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] w32 [10] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h0, 32'h7FFFFFFF,
                                  32'h80000000, 32'd32, 32'd64, 32'd256, 32'd256};
        logic [4:0]  x32 [10] = '{5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b10000,
                                  5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        logic [7:0]  w8 [10] = '{8'h7F, 8'hFF, 8'h80, 8'h00, 8'h7F,
                                 8'h80, 8'd32, 8'd64, 8'h7F, 8'hFF};
        logic [4:0]  x8 [10] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b10000,
                                 5'b10000, 5'b00000, 5'b00000, 5'b00100, 5'b00100};
        logic [31:0] r32; logic [4:0] e32; logic [7:0] r8; logic [4:0] e8;
        int lat; bit ok;
        for (int i = 0; i < 10; i++) begin
            xfer(fv[i], 2'b00, sv[i], 1'b0, r32, e32, r8, e8, lat, ok);
            $display("range f=%h signed=%b -> w32 %h/%b w8 %h/%b", fv[i], sv[i], r32, e32, r8, e8);
            checks++; if (!ok || r32 !== w32[i] || e32 !== x32[i])
                $display("FAIL range32_%h_s%b got=%h/%b want=%h/%b", fv[i], sv[i], r32, e32, w32[i], x32[i]); else passed++;
            checks++; if (!ok || r8 !== w8[i] || e8 !== x8[i])
                $display("FAIL range8_%h_s%b got=%h/%b want=%h/%b", fv[i], sv[i], r8, e8, w8[i], x8[i]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] fv [4] = '{16'h3E00, 16'h4000, 16'h4080, 16'h4200};
        logic [1:0]  mv [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
        logic [31:0] wv [4] = '{32'd1, 32'd2, 32'd2, 32'd4};
        int idx = 0, got = 0, n = 0;
        bit stall_bad = 1'b0, extra = 1'b0;
        out_ready = 1'b0; signed_out = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin float_in = fv[idx]; rnd_mode = mv[idx]; end
            #1;
            if (out_valid32 && int_out32 !== 32'd1) stall_bad = 1'b1;
            if (in_valid && in_ready32) idx++;
            @(posedge clk); #1;
        end
        $display("backpressure accepted=%0d in_ready=%b out=%h", idx, in_ready32, int_out32);
        checks++; if (idx !== 2 || in_ready32 !== 1'b0)
            $display("FAIL bp_accepts got=%0d/%b want=2/0", idx, in_ready32); else passed++;
        checks++; if (stall_bad || out_valid32 !== 1'b1 || int_out32 !== 32'd1)
            $display("FAIL bp_stall_hold got=%b/%h want=1/00000001", out_valid32, int_out32); else passed++;
        out_ready = 1'b1;
        while (got < 4 && n < 40) begin
            in_valid = (idx < 4);
            if (idx < 4) begin float_in = fv[idx]; rnd_mode = mv[idx]; end
            #1;
            if (in_valid && in_ready32) idx++;
            if (out_valid32) begin
                $display("backpressure out[%0d]=%h", got, int_out32);
                checks++; if (int_out32 !== wv[got])
                    $display("FAIL bp_out%0d got=%h want=%h", got, int_out32, wv[got]); else passed++;
                got++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        repeat (4) begin
            if (out_valid32) extra = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (got !== 4 || extra)
            $display("FAIL bp_count got=%0d extra=%b want=4/0", got, extra); else passed++;
    endtask

    task automatic test_sticky();
        logic [31:0] r32; logic [4:0] e32; logic [7:0] r8; logic [4:0] e8;
        int lat; bit ok;
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        checks++; if (sticky32 !== 5'd0) $display("FAIL sticky_clear got=%b want=00000", sticky32); else passed++;
        xfer(16'h7E00, 2'b00, 1'b1, 1'b0, r32, e32, r8, e8, lat, ok);
        xfer(16'h4080, 2'b00, 1'b1, 1'b0, r32, e32, r8, e8, lat, ok);
        $display("sticky after 7E00,4080: %b / %b", sticky32, sticky8);
        checks++; if (sticky32 !== 5'b10001 || sticky8 !== 5'b10001)
            $display("FAIL sticky_accum got=%b/%b want=10001", sticky32, sticky8); else passed++;
        xfer(16'h7E00, 2'b00, 1'b1, 1'b0, r32, e32, r8, e8, lat, ok);
        xfer(16'h4080, 2'b00, 1'b1, 1'b1, r32, e32, r8, e8, lat, ok);
        $display("sticky after clear with 4080: %b", sticky32);
        checks++; if (sticky32 !== 5'b00001)
            $display("FAIL sticky_clr_coincide got=%b want=00001", sticky32); else passed++;
    endtask

    task automatic test_random();
        localparam int N = 80;
        logic [36:0] q32 [$];
        logic [12:0] q8 [$];
        logic [36:0] e32v;
        logic [12:0] e8v;
        longint res; logic [4:0] exc;
        logic [15:0] cf; logic [1:0] cm; logic cs;
        logic [5:0] ex;
        int idx = 0, got = 0, n = 0, r;
        bit need = 1'b1;
        while (got < N && n < 3000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (idx < N && need) begin
                r  = $urandom_range(0, 9);
                ex = (r == 0) ? 6'd0 : (r == 1) ? 6'd63 : 6'($urandom_range(22, 63));
                cf = {1'($urandom_range(0, 1)), ex, 9'($urandom_range(0, 511))};
                cm = 2'($urandom_range(0, 3));
                cs = 1'($urandom_range(0, 1));
                need = 1'b0;
            end
            in_valid = (idx < N);
            float_in = cf; rnd_mode = cm; signed_out = cs;
            #1;
            if (in_valid && in_ready32) begin
                ref_conv(cf, cm, cs, 32, res, exc);
                q32.push_back({exc, res[31:0]});
                ref_conv(cf, cm, cs, 8, res, exc);
                q8.push_back({exc, res[7:0]});
                idx++;
                need = 1'b1;
            end
            if (out_valid32 && out_ready) begin
                checks++;
                if (q32.size() == 0 || q8.size() == 0) begin
                    $display("FAIL rand_unexpected_out got=%h want=none", int_out32);
                end else begin
                    e32v = q32.pop_front();
                    e8v  = q8.pop_front();
                    $display("rand #%0d -> %h/%b (8b %h/%b)", got, int_out32, exc32, int_out8, exc8);
                    if ({exc32, int_out32} !== e32v || {exc8, int_out8} !== e8v)
                        $display("FAIL rand_%0d got=%b/%h %b/%h want=%b/%h %b/%h", got, exc32, int_out32,
                                 exc8, int_out8, e32v[36:32], e32v[31:0], e8v[12:8], e8v[7:0]);
                    else passed++;
                end
                got++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got !== N) $display("FAIL rand_count got=%0d want=%0d", got, N); else passed++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        bit stale = 1'b0;
        out_ready = 1'b0; signed_out = 1'b1; rnd_mode = 2'b00;
        for (int c = 0; c < 4; c++) begin
            float_in = 16'h4000 + 16'(c * 512);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: in_ready=%b out_valid=%b out=%h exc=%b sticky=%b",
                 in_ready32, out_valid32, int_out32, exc32, sticky32);
        checks++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0)
            $display("FAIL midrst_handshake got=%b/%b want=1/0", in_ready32, out_valid32); else passed++;
        checks++; if (int_out32 !== 32'd0 || exc32 !== 5'd0 || sticky32 !== 5'd0 || int_out8 !== 8'd0)
            $display("FAIL midrst_outputs got=%h/%b/%b want=0/0/0", int_out32, exc32, sticky32); else passed++;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            if (out_valid32) stale = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (stale) $display("FAIL midrst_stale got=1 want=0"); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_backpressure();
        test_sticky();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
